// File: rtl/axis_checksum_append.sv
// AXI-Stream pass-through that forwards 64-bit words, optionally half-swapped, and
// appends one {word count, 32-bit wrapping sum} trailer word after each packet.
module axis_checksum_append #(
    parameter int C_AXIS_DATA_WIDTH = 64,
    parameter int C_CNT_WIDTH       = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [C_AXIS_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                         s_axis_tvalid,
    output logic                         s_axis_tready,
    input  logic                         s_axis_tlast,
    output logic [C_AXIS_DATA_WIDTH-1:0] m_axis_tdata,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic                         m_axis_tlast,
    input  logic                         swap_en,
    output logic                         pkt_done,
    output logic                         busy
);

    localparam int HW = C_AXIS_DATA_WIDTH / 2;

    if (C_AXIS_DATA_WIDTH != 64) begin : g_bad_data_width
        $error("axis_checksum_append: only C_AXIS_DATA_WIDTH=64 is supported");
    end
    if (2 * C_CNT_WIDTH != C_AXIS_DATA_WIDTH) begin : g_bad_cnt_width
        $error("axis_checksum_append: 2*C_CNT_WIDTH must equal C_AXIS_DATA_WIDTH");
    end

    typedef enum logic {
        PASS    = 1'b0,
        TRAILER = 1'b1
    } state_t;

    state_t                         r_state;
    state_t                         w_state_nxt;
    logic [C_AXIS_DATA_WIDTH-1:0]   r_tdata;
    logic                           r_tvalid;
    logic                           r_tlast;
    logic [C_CNT_WIDTH-1:0]         r_cnt;
    logic [C_CNT_WIDTH-1:0]         r_sum;
    logic                           r_pkt_done;
    logic                           r_busy;

    logic                           w_slot_free;
    logic                           w_s_hs;
    logic                           w_trl_hs;
    logic [C_AXIS_DATA_WIDTH-1:0]   w_swapped;
    logic [C_CNT_WIDTH-1:0]         w_sum_nxt;

    assign w_slot_free   = !r_tvalid || m_axis_tready;
    assign s_axis_tready = !rst && (r_state == PASS) && w_slot_free;
    assign w_s_hs        = s_axis_tvalid && s_axis_tready;
    assign w_trl_hs      = r_tvalid && m_axis_tready && r_tlast;
    assign w_swapped     = {s_axis_tdata[HW-1:0], s_axis_tdata[C_AXIS_DATA_WIDTH-1:HW]};
    // Checksum always covers the unswapped input halves.
    assign w_sum_nxt     = r_sum + s_axis_tdata[C_AXIS_DATA_WIDTH-1:HW] + s_axis_tdata[HW-1:0];

    assign m_axis_tdata  = r_tdata;
    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tlast  = r_tlast;
    assign pkt_done      = r_pkt_done;
    assign busy          = r_busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= PASS;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            PASS:    if (w_s_hs && s_axis_tlast) w_state_nxt = TRAILER;
            TRAILER: if (w_slot_free)            w_state_nxt = PASS;
            default: w_state_nxt = PASS;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tdata    <= '0;
            r_tvalid   <= 1'b0;
            r_tlast    <= 1'b0;
            r_cnt      <= '0;
            r_sum      <= '0;
            r_pkt_done <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_pkt_done <= w_trl_hs;
            if (w_trl_hs) begin
                r_busy <= 1'b0;
            end
            case (r_state)
                PASS: begin
                    if (w_s_hs) begin
                        r_tdata  <= swap_en ? w_swapped : s_axis_tdata;
                        r_tvalid <= 1'b1;
                        r_tlast  <= 1'b0;
                        r_cnt    <= r_cnt + 1'b1;
                        r_sum    <= w_sum_nxt;
                        r_busy   <= 1'b1;
                    end else if (w_slot_free) begin
                        r_tvalid <= 1'b0;
                    end
                end
                TRAILER: begin
                    // Counters already include the last data word, loaded on its accept.
                    if (w_slot_free) begin
                        r_tdata  <= {r_cnt, r_sum};
                        r_tvalid <= 1'b1;
                        r_tlast  <= 1'b1;
                        r_cnt    <= '0;
                        r_sum    <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
